operand_fwd_stage: RTL and testbench

//   Parametrised successor to the single-cycle operand muxes, for the pipelined datapath.

---
 rtl/operand_fwd_stage_if.sv | 38 +++
 rtl/operand_fwd_stage.sv | 104 ++++++++++
 tb/tb_operand_fwd_stage.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_fwd_stage_if.sv
// Decode-to-execute operand bus: D-side operands, forwarding sources and the registered E-side pair.
interface operand_fwd_stage_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NFWD  = 3,
  parameter int unsigned AW    = 5,
  parameter int unsigned CNTW  = 16
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [AW-1:0]         rs_addr;
  logic [AW-1:0]         rt_addr;
  logic [WIDTH-1:0]      rs_data;
  logic [WIDTH-1:0]      rt_data;
  logic [WIDTH-1:0]      imm;
  logic                  bsel_imm;
  logic [NFWD-1:0]       fwd_valid;
  logic [NFWD-1:0]       fwd_rdy;
  logic [NFWD*AW-1:0]    fwd_addr;
  logic [NFWD*WIDTH-1:0] fwd_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      op_a;
  logic [WIDTH-1:0]      op_b;
  logic [CNTW-1:0]       stall_cnt;

  modport master (
    output flush, in_valid, rs_addr, rt_addr, rs_data, rt_data, imm, bsel_imm,
           fwd_valid, fwd_rdy, fwd_addr, fwd_data, out_ready,
    input  in_ready, out_valid, op_a, op_b, stall_cnt
  );

  modport slave (
    input  flush, in_valid, rs_addr, rt_addr, rs_data, rt_data, imm, bsel_imm,
           fwd_valid, fwd_rdy, fwd_addr, fwd_data, out_ready,
    output in_ready, out_valid, op_a, op_b, stall_cnt
  );
endinterface

// File: rtl/operand_fwd_stage.sv
// D-to-E operand stage: priority forwarding, load-use interlock and a one-entry
// valid/ready operand register with flush and a saturating interlock counter.
module operand_fwd_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NFWD  = 3,
  parameter int unsigned AW    = 5,
  parameter int unsigned CNTW  = 16
) (
  input logic                clk,
  input logic                reset_n,
  operand_fwd_stage_if.slave bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             hit_a, hit_b, rdy_a, rdy_b;
  logic [WIDTH-1:0] fwd_a, fwd_b;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             rs_nz, rt_nz;
  logic             haz_a, haz_b, hazard;
  logic             in_ready_c, load;
  logic [WIDTH-1:0] op_a_q, op_b_q;
  logic [CNTW-1:0]  stall_q;

  // Walk sources oldest-first so the youngest (lowest index) match wins.
  always_comb begin
    hit_a = 1'b0;
    rdy_a = 1'b0;
    fwd_a = '0;
    hit_b = 1'b0;
    rdy_b = 1'b0;
    fwd_b = '0;
    for (int i = int'(NFWD) - 1; i >= 0; i--) begin
      if (bus.fwd_valid[i] && (bus.fwd_addr[i*AW +: AW] == bus.rs_addr)) begin
        hit_a = 1'b1;
        rdy_a = bus.fwd_rdy[i];
        fwd_a = bus.fwd_data[i*WIDTH +: WIDTH];
      end
      if (bus.fwd_valid[i] && (bus.fwd_addr[i*AW +: AW] == bus.rt_addr)) begin
        hit_b = 1'b1;
        rdy_b = bus.fwd_rdy[i];
        fwd_b = bus.fwd_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign rs_nz = |bus.rs_addr;
  assign rt_nz = |bus.rt_addr;

  // Register 0 reads as zero and is never forwarded or interlocked.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    if (rs_nz) sel_a = hit_a ? fwd_a : bus.rs_data;
    if (bus.bsel_imm)  sel_b = bus.imm;
    else if (rt_nz)    sel_b = hit_b ? fwd_b : bus.rt_data;
  end

  assign haz_a  = rs_nz && hit_a && !rdy_a;
  assign haz_b  = !bus.bsel_imm && rt_nz && hit_b && !rdy_b;
  assign hazard = haz_a || haz_b;

  assign in_ready_c   = !bus.flush && !hazard && ((state_q == EMPTY) || bus.out_ready);
  assign load         = bus.in_valid && in_ready_c;
  assign bus.in_ready = in_ready_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= EMPTY;
    else          state_q <= state_d;
  end

  // Flush beats load, load beats plain consume.
  always_comb begin
    state_d = state_q;
    if (bus.flush)                              state_d = EMPTY;
    else if (load)                              state_d = FULL;
    else if ((state_q == FULL) && bus.out_ready) state_d = EMPTY;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_a_q <= '0;
      op_b_q <= '0;
    end else if (load) begin
      op_a_q <= sel_a;
      op_b_q <= sel_b;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (bus.in_valid && hazard && !bus.flush && (stall_q != '1)) begin
      stall_q <= stall_q + CNTW'(1);
    end
  end

  assign bus.out_valid = (state_q == FULL);
  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;
  assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_operand_fwd_stage.sv
// Scoreboard bench for operand_fwd_stage: main instance plus a CNTW=2 instance for saturation.
module tb_operand_fwd_stage;

  localparam int unsigned W = 32;
  localparam int unsigned A = 5;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } pair_t;

  logic  clk = 1'b0;
  logic  reset_n;
  int    errors = 0;
  int    checks = 0;
  pair_t sb[$];
  pair_t exp_p;

  operand_fwd_stage_if #(.WIDTH(W), .NFWD(3), .AW(A), .CNTW(16)) bus ();
  operand_fwd_stage_if #(.WIDTH(W), .NFWD(3), .AW(A), .CNTW(2))  sbus ();

  operand_fwd_stage #(.WIDTH(W), .NFWD(3), .AW(A), .CNTW(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  operand_fwd_stage #(.WIDTH(W), .NFWD(3), .AW(A), .CNTW(2)) u_sat (
    .clk(clk), .reset_n(reset_n), .bus(sbus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush = 0; bus.in_valid = 0; bus.rs_addr = '0; bus.rt_addr = '0;
    bus.rs_data = '0; bus.rt_data = '0; bus.imm = '0; bus.bsel_imm = 0;
    bus.fwd_valid = '0; bus.fwd_rdy = '0; bus.fwd_addr = '0; bus.fwd_data = '0;
    bus.out_ready = 1;
    sbus.flush = 0; sbus.in_valid = 0; sbus.rs_addr = '0; sbus.rt_addr = '0;
    sbus.rs_data = '0; sbus.rt_data = '0; sbus.imm = '0; sbus.bsel_imm = 0;
    sbus.fwd_valid = '0; sbus.fwd_rdy = '0; sbus.fwd_addr = '0; sbus.fwd_data = '0;
    sbus.out_ready = 1;
  endtask

  task automatic set_fwd(input int i, input bit v, input bit r, input logic [A-1:0] a,
                         input logic [W-1:0] d);
    bus.fwd_valid[i]        = v;
    bus.fwd_rdy[i]          = r;
    bus.fwd_addr[i*A +: A]  = a;
    bus.fwd_data[i*W +: W]  = d;
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    pair_t p;
    p.a = a;
    p.b = b;
    sb.push_back(p);
  endtask

  task automatic drain();
    bus.in_valid = 0; bus.flush = 0; bus.out_ready = 1;
    tick();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.op_a !== '0 || bus.op_b !== '0 || bus.stall_cnt !== '0) begin
      errors++;
      $display("FAIL reset_init: v=%b a=%h b=%h cnt=%0d, expected all zero",
               bus.out_valid, bus.op_a, bus.op_b, bus.stall_cnt);
    end
    reset_n = 1;
    tick();
    bus.rs_addr = 5'd3; bus.rs_data = 32'h1234; bus.out_ready = 0; bus.in_valid = 1;
    push(32'h1234, 32'h0);
    tick();
    bus.in_valid = 0;
    exp_p = sb.pop_front();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.op_a !== exp_p.a || bus.op_b !== exp_p.b) begin
      errors++;
      $display("FAIL reset_fill: v=%b a=%h b=%h, expected v=1 a=%h b=%h",
               bus.out_valid, bus.op_a, bus.op_b, exp_p.a, exp_p.b);
    end
    #2 reset_n = 0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.op_a !== '0 || bus.op_b !== '0 || bus.stall_cnt !== '0) begin
      errors++;
      $display("FAIL reset_async: v=%b a=%h b=%h cnt=%0d, expected all zero",
               bus.out_valid, bus.op_a, bus.op_b, bus.stall_cnt);
    end
    #2 reset_n = 1;
    bus.out_ready = 1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: out_valid=%b, expected 0", bus.out_valid);
    end
  endtask

  task automatic test_no_fwd();
    bus.rs_addr = 5'd3; bus.rs_data = 32'h11; bus.rt_addr = 5'd4; bus.rt_data = 32'h22;
    bus.bsel_imm = 0; bus.in_valid = 1; bus.out_ready = 1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL nofwd_ready: in_ready=%b, expected 1", bus.in_ready);
    end
    push(32'h11, 32'h22);
    tick();
    bus.in_valid = 0;
    exp_p = sb.pop_front();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.op_a !== exp_p.a || bus.op_b !== exp_p.b) begin
      errors++;
      $display("FAIL nofwd_pair: v=%b a=%h b=%h, expected v=1 a=%h b=%h",
               bus.out_valid, bus.op_a, bus.op_b, exp_p.a, exp_p.b);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL nofwd_consume: out_valid=%b, expected 0", bus.out_valid);
    end
  endtask

  task automatic test_priority();
    logic [W-1:0] ea [3];
    logic [A-1:0] rs [3];
    bit           v0 [3];
    ea = '{32'hAAAA, 32'hBBBB, 32'h0};
    rs = '{5'd3, 5'd3, 5'd0};
    v0 = '{1'b1, 1'b0, 1'b1};
    bus.rt_addr = 5'd4; bus.rt_data = 32'h22; bus.rs_data = 32'h99; bus.bsel_imm = 0;
    bus.out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      set_fwd(0, v0[k], 1'b1, rs[k], 32'hAAAA);
      set_fwd(1, 1'b1, 1'b1, 5'd3, 32'hBBBB);
      set_fwd(2, 1'b1, 1'b1, 5'd4, 32'hCCCC);
      bus.rs_addr = rs[k];
      bus.in_valid = 1;
      push(ea[k], 32'hCCCC);
      tick();
      exp_p = sb.pop_front();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.op_a !== exp_p.a || bus.op_b !== exp_p.b) begin
        errors++;
        $display("FAIL prio_%0d: v=%b a=%h b=%h, expected v=1 a=%h b=%h",
                 k, bus.out_valid, bus.op_a, bus.op_b, exp_p.a, exp_p.b);
      end
    end
    bus.fwd_valid = '0;
    drain();
  endtask

  task automatic test_load_use();
    bus.rs_addr = 5'd3; bus.rs_data = 32'h11; bus.rt_addr = 5'd4; bus.rt_data = 32'h22;
    bus.bsel_imm = 0; bus.in_valid = 0;
    set_fwd(0, 1'b1, 1'b0, 5'd4, 32'h55);
    set_fwd(1, 1'b1, 1'b1, 5'd4, 32'hBBBB);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL lu_mask: in_ready=%b, expected 0", bus.in_ready);
    end
    tick();
    bus.in_valid = 1; bus.flush = 1;
    tick();
    checks++;
    if (bus.stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL lu_nocount: stall_cnt=%0d, expected 0", bus.stall_cnt);
    end
    bus.flush = 0;
    tick();
    tick();
    checks++;
    if (bus.stall_cnt !== 16'd2 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL lu_stall: stall_cnt=%0d v=%b, expected 2 v=0", bus.stall_cnt, bus.out_valid);
    end
    bus.fwd_rdy[0] = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL lu_release: in_ready=%b, expected 1", bus.in_ready);
    end
    push(32'h11, 32'h55);
    tick();
    exp_p = sb.pop_front();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.op_a !== exp_p.a || bus.op_b !== exp_p.b || bus.stall_cnt !== 16'd2) begin
      errors++;
      $display("FAIL lu_fwd: v=%b a=%h b=%h cnt=%0d, expected v=1 a=%h b=%h cnt=2",
               bus.out_valid, bus.op_a, bus.op_b, bus.stall_cnt, exp_p.a, exp_p.b);
    end
    bus.fwd_rdy[0] = 1'b0; bus.bsel_imm = 1; bus.imm = 32'hFFFF0000;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL lu_imm_ready: in_ready=%b, expected 1", bus.in_ready);
    end
    push(32'h11, 32'hFFFF0000);
    tick();
    exp_p = sb.pop_front();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.op_a !== exp_p.a || bus.op_b !== exp_p.b || bus.stall_cnt !== 16'd2) begin
      errors++;
      $display("FAIL lu_imm: v=%b a=%h b=%h cnt=%0d, expected v=1 a=%h b=%h cnt=2",
               bus.out_valid, bus.op_a, bus.op_b, bus.stall_cnt, exp_p.a, exp_p.b);
    end
    bus.fwd_valid = '0; bus.bsel_imm = 0;
    drain();
  endtask

  task automatic test_backpressure();
    bus.rs_addr = 5'd3; bus.rs_data = 32'h11; bus.rt_addr = 5'd4; bus.rt_data = 32'h22;
    bus.in_valid = 1; bus.out_ready = 0;
    push(32'h11, 32'h22);
    tick();
    bus.rs_data = 32'h77;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready: in_ready=%b, expected 0", bus.in_ready);
    end
    tick();
    tick();
    exp_p = sb.pop_front();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.op_a !== exp_p.a || bus.op_b !== exp_p.b) begin
      errors++;
      $display("FAIL bp_hold: v=%b a=%h b=%h, expected v=1 a=%h b=%h",
               bus.out_valid, bus.op_a, bus.op_b, exp_p.a, exp_p.b);
    end
    bus.flush = 1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: in_ready=%b, expected 0", bus.in_ready);
    end
    tick();
    bus.flush = 0; bus.in_valid = 0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.op_a !== 32'h11 || sb.size() != 0) begin
      errors++;
      $display("FAIL flush_kill: v=%b a=%h pending=%0d, expected v=0 a=00000011 pending=0",
               bus.out_valid, bus.op_a, sb.size());
    end
    drain();
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1; bus.bsel_imm = 0;
    for (int k = 0; k < 4; k++) begin
      bus.rs_data = 32'h100 + 32'(k);
      bus.rt_data = 32'h200 + 32'(k);
      bus.in_valid = 1;
      push(32'h100 + 32'(k), 32'h200 + 32'(k));
      tick();
      exp_p = sb.pop_front();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.op_a !== exp_p.a || bus.op_b !== exp_p.b) begin
        errors++;
        $display("FAIL b2b_%0d: v=%b a=%h b=%h, expected v=1 a=%h b=%h",
                 k, bus.out_valid, bus.op_a, bus.op_b, exp_p.a, exp_p.b);
      end
    end
    drain();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: out_valid=%b, expected 0", bus.out_valid);
    end
  endtask

  task automatic test_saturation();
    int unsigned exp_cnt;
    sbus.fwd_valid = 3'b001; sbus.fwd_rdy = 3'b000; sbus.fwd_addr[A-1:0] = 5'd4;
    sbus.rt_addr = 5'd4; sbus.bsel_imm = 0; sbus.in_valid = 1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_cnt = (k > 3) ? 3 : k;
      checks++;
      if (sbus.stall_cnt !== 2'(exp_cnt) || sbus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL sat_%0d: stall_cnt=%0d v=%b, expected %0d v=0",
                 k, sbus.stall_cnt, sbus.out_valid, exp_cnt);
      end
    end
    sbus.in_valid = 0;
  endtask

  initial begin
    reset_n = 0;
    idle();
    test_reset();
    test_no_fwd();
    test_priority();
    test_load_use();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
